argmax_layer: RTL

Final classification stage of the BNN pipeline. Sits directly downstream of the third middle layer. Takes its ten 6-bit class scores over the layer req/ack handshake, scans them sequentially for the highest score and the runner-up, and offers the class index, the winning score and the winning margin to the downstream consumer (host/display) over the same handshake.

---
 rtl/argmax_layer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/argmax_layer.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_layer
//  Description : Final BNN classification stage. Receives ten 6-bit class
//                scores over the req/ack handshake, scans them one per cycle
//                for the highest score and the runner-up, and offers class
//                index, winning score and winning margin downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_layer (
    input  logic       clk,
    input  logic       xrst,
    input  logic [5:0] score0,
    input  logic [5:0] score1,
    input  logic [5:0] score2,
    input  logic [5:0] score3,
    input  logic [5:0] score4,
    input  logic [5:0] score5,
    input  logic [5:0] score6,
    input  logic [5:0] score7,
    input  logic [5:0] score8,
    input  logic [5:0] score9,
    input  logic       rcv_ack,
    output logic       rcv_req,
    input  logic       snd_req,
    output logic       snd_ack,
    output logic [3:0] class_out,
    output logic [5:0] max_out,
    output logic [5:0] margin_out
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_RCV      = 3'd1,
        ST_CALC     = 3'd2,
        ST_SND_WAIT = 3'd3,
        ST_SND      = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t     state;
    logic [5:0] score_mem [10];
    logic [5:0] best;
    logic [5:0] second;
    logic [3:0] best_idx;
    logic [3:0] idx;

    logic [5:0] cur;
    logic [5:0] best_nx;
    logic [5:0] second_nx;
    logic [3:0] best_idx_nx;

    // Select the score under scan; idx never leaves 0..9 in normal operation
    always_comb begin
        cur = 6'd0;
        case (idx)
            4'd0:    cur = score_mem[0];
            4'd1:    cur = score_mem[1];
            4'd2:    cur = score_mem[2];
            4'd3:    cur = score_mem[3];
            4'd4:    cur = score_mem[4];
            4'd5:    cur = score_mem[5];
            4'd6:    cur = score_mem[6];
            4'd7:    cur = score_mem[7];
            4'd8:    cur = score_mem[8];
            4'd9:    cur = score_mem[9];
            default: cur = 6'd0;
        endcase
    end

    // One scan step: strict compares so the lowest index wins a tie and the
    // tied value drops into second, giving a zero margin
    always_comb begin
        best_nx     = best;
        second_nx   = second;
        best_idx_nx = best_idx;
        if (idx == 4'd0) begin
            best_nx     = cur;
            second_nx   = 6'd0;
            best_idx_nx = 4'd0;
        end else if (cur > best) begin
            second_nx   = best;
            best_nx     = cur;
            best_idx_nx = idx;
        end else if (cur > second) begin
            second_nx   = cur;
        end
    end

    // Control FSM, score capture, scan registers and registered result/handshake outputs
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= ST_WAIT;
            rcv_req    <= 1'b1;
            snd_ack    <= 1'b0;
            class_out  <= 4'd0;
            max_out    <= 6'd0;
            margin_out <= 6'd0;
            best       <= 6'd0;
            second     <= 6'd0;
            best_idx   <= 4'd0;
            idx        <= 4'd0;
            for (int i = 0; i < 10; i++) begin
                score_mem[i] <= 6'd0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    if (rcv_ack) begin
                        state   <= ST_RCV;
                        rcv_req <= 1'b0;
                    end
                end
                ST_RCV: begin
                    score_mem[0] <= score0;
                    score_mem[1] <= score1;
                    score_mem[2] <= score2;
                    score_mem[3] <= score3;
                    score_mem[4] <= score4;
                    score_mem[5] <= score5;
                    score_mem[6] <= score6;
                    score_mem[7] <= score7;
                    score_mem[8] <= score8;
                    score_mem[9] <= score9;
                    idx          <= 4'd0;
                    state        <= ST_CALC;
                end
                ST_CALC: begin
                    best     <= best_nx;
                    second   <= second_nx;
                    best_idx <= best_idx_nx;
                    if (idx == LAST_IDX) begin
                        // Commit from the next-values so the last score counts
                        class_out  <= best_idx_nx;
                        max_out    <= best_nx;
                        margin_out <= best_nx - second_nx;
                        idx        <= 4'd0;
                        state      <= ST_SND_WAIT;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_SND_WAIT: begin
                    if (snd_req) begin
                        state   <= ST_SND;
                        snd_ack <= 1'b1;
                    end
                end
                ST_SND: begin
                    if (!snd_req) begin
                        state   <= ST_WAIT;
                        snd_ack <= 1'b0;
                        rcv_req <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_WAIT;
                    rcv_req <= 1'b1;
                    snd_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
